// File: rtl/nvram_upload_ctrl.sv
// nvram_upload_ctrl: serves hps_io upload reads from the battery-backed CMOS RAM via the core RAM arbiter.
// Optional NVRAM_UPLOAD_CSUM_EN returns a two's-complement checksum byte at address 2^ADDR_W.
module nvram_upload_ctrl #(
  parameter int unsigned ADDR_W       = 10,
  parameter logic [7:0]  UPLOAD_INDEX = 8'd4,
  parameter int unsigned RD_LAT       = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              ram_req,
  input  logic              ram_gnt,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_q,
  output logic              upload_active,
  output logic              overrun
);

  localparam logic [24:0] RAM_SIZE = 25'(1) << ADDR_W;
  localparam logic [1:0]  LAT_LAST = 2'(RD_LAT);

  typedef enum logic [1:0] {IDLE, ARB, RD, OOR} state_t;

  state_t            state_q;
  logic [7:0]        din_q;
  logic              wait_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_q;
  logic              active_q;
  logic              overrun_q;
  logic [1:0]        lat_q;
`ifdef NVRAM_UPLOAD_CSUM_EN
  logic [7:0]        sum_q;
  logic              csum_sel_q;
  logic              csum_hold_q;
`endif

  logic active_d;
  logic active_rise;
  logic rd_valid;
  logic in_range;

  assign active_d    = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  assign active_rise = active_d && !active_q;
  assign rd_valid    = ioctl_rd && active_q && (ioctl_index == UPLOAD_INDEX);
  assign in_range    = ioctl_addr < RAM_SIZE;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      din_q       <= 8'h00;
      wait_q      <= 1'b0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      active_q    <= 1'b0;
      overrun_q   <= 1'b0;
      lat_q       <= 2'd0;
`ifdef NVRAM_UPLOAD_CSUM_EN
      sum_q       <= 8'h00;
      csum_sel_q  <= 1'b0;
      csum_hold_q <= 1'b0;
`endif
    end else begin
      active_q <= active_d;

      if (active_rise) begin
        overrun_q <= 1'b0;
`ifdef NVRAM_UPLOAD_CSUM_EN
        sum_q     <= 8'h00;
`endif
      end else if (rd_valid && state_q != IDLE) begin
        overrun_q <= 1'b1;
      end

      // Losing the session aborts whatever is in flight; a late grant is ignored.
      if (!active_q) begin
        state_q <= IDLE;
        wait_q  <= 1'b0;
        req_q   <= 1'b0;
        rd_q    <= 1'b0;
`ifdef NVRAM_UPLOAD_CSUM_EN
        csum_hold_q <= 1'b0;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            if (rd_valid) begin
              wait_q <= 1'b1;
              if (in_range) begin
                addr_q  <= ioctl_addr[ADDR_W-1:0];
                req_q   <= 1'b1;
                state_q <= ARB;
              end else begin
                state_q <= OOR;
`ifdef NVRAM_UPLOAD_CSUM_EN
                csum_sel_q  <= (ioctl_addr == RAM_SIZE);
                csum_hold_q <= (ioctl_addr == RAM_SIZE);
`endif
              end
            end
          end
          ARB: begin
            if (ram_gnt) begin
              rd_q    <= 1'b1;
              lat_q   <= 2'd0;
              state_q <= RD;
            end
          end
          RD: begin
            rd_q <= 1'b0;
            if (lat_q == LAT_LAST) begin
              din_q   <= ram_q;
              wait_q  <= 1'b0;
              req_q   <= 1'b0;
              state_q <= IDLE;
`ifdef NVRAM_UPLOAD_CSUM_EN
              sum_q   <= sum_q + ram_q;
`endif
            end else begin
              lat_q <= lat_q + 2'd1;
            end
          end
          OOR: begin
`ifdef NVRAM_UPLOAD_CSUM_EN
            if (csum_hold_q) begin
              csum_hold_q <= 1'b0;
            end else begin
              din_q   <= csum_sel_q ? (8'h00 - sum_q) : 8'hFF;
              wait_q  <= 1'b0;
              state_q <= IDLE;
            end
`else
            din_q   <= 8'hFF;
            wait_q  <= 1'b0;
            state_q <= IDLE;
`endif
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ioctl_din     = din_q;
  assign ioctl_wait    = wait_q;
  assign ram_req       = req_q;
  assign ram_addr      = addr_q;
  assign ram_rd        = rd_q;
  assign upload_active = active_q;
  assign overrun       = overrun_q;

endmodule
